gpio_mul_sched: RTL and testbench

Bus-mapped scheduler for the 24×24 multiply/popcount peripheral. Software pushes operand pairs into a job queue. A sequential engine drains the queue one job at a time: 24-step shift-add multiply, then popcount of the low product word. Each result is parked in a result queue for bus readout, and a completed-operation counter is mirrored on `gpio_out`.

---
 rtl/gpio_mul_pkg.sv | 43 ++++
 rtl/mul_sched_fifo.sv | 58 +++++
 rtl/gpio_mul_sched.sv | 205 ++++++++++++++++++++
 tb/tb_gpio_mul_sched.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/gpio_mul_pkg.sv
// Shared constants, engine state encoding and helpers
// for the 24x24 multiply/popcount scheduler.
package gpio_mul_pkg;

  localparam logic [15:0] ADDR_A1  = 16'h0380;
  localparam logic [15:0] ADDR_A2  = 16'h0388;
  localparam logic [15:0] ADDR_W   = 16'h0390;
  localparam logic [15:0] ADDR_L   = 16'h0398;
  localparam logic [15:0] ADDR_CSR = 16'h03A0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MUL,
    POP,
    STORE
  } eng_state_e;

  localparam int ST_BUSY   = 0;
  localparam int ST_JCNT   = 1;
  localparam int ST_RCNT   = 4;
  localparam int ST_EFULL  = 7;
  localparam int ST_EEMPTY = 8;
  localparam int ST_IEN    = 9;

  localparam int CT_CLR   = 0;
  localparam int CT_FLUSH = 1;
  localparam int CT_IEN   = 2;

  localparam int JOB_W = 48;
  localparam int RES_W = 39;

  function automatic logic [5:0] popcnt32(
    input logic [31:0] v
  );
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++)
      n = n + {5'h0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/mul_sched_fifo.sv
// Synchronous FIFO with flush; full/empty
// come from the registered occupancy count.
module mul_sched_fifo #(
  parameter int W  = 8,
  parameter int D  = 4,
  parameter int AW = $clog2(D),
  parameter int CW = $clog2(D) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [D];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CW'(D));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (do_push && !flush_i)
      mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push)
        wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)
        rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/gpio_mul_sched.sv
// Bus-mapped job scheduler: queues operand pairs, runs a
// shift-add multiply plus popcount, queues results for readout.
module gpio_mul_sched
  import gpio_mul_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  output logic [31:0] gpio_out,
  output logic        irq
);

  localparam int CW = $clog2(QDEPTH) + 1;

  eng_state_e  state_q, state_d;
  logic [47:0] acc_q, acc_d;
  logic [47:0] mcand_q, mcand_d;
  logic [23:0] mplier_q, mplier_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] w_q, w_d;
  logic        v_q, v_d;
  logic [5:0]  l_q, l_d;

  logic [23:0] a1_q;
  logic [15:0] op_cnt_q;
  logic [31:0] sdata_out_q;
  logic        err_full_q, err_empty_q, ien_q, irq_q;

  logic [JOB_W-1:0] job_head;
  logic [RES_W-1:0] res_head;
  logic             job_full, job_empty, res_full, res_empty;
  logic [CW-1:0]    job_cnt, res_cnt;
  logic             job_pop, res_push;
  logic [31:0]      status, rdata;
  logic             unused_bits;

  logic wr_a1, wr_a2, wr_csr, rd_w, flush;
  assign wr_a1  = swr & (saddress == ADDR_A1);
  assign wr_a2  = swr & (saddress == ADDR_A2);
  assign wr_csr = swr & (saddress == ADDR_CSR);
  assign rd_w   = srd & (saddress == ADDR_W);
  assign flush  = wr_csr & sdata_in[CT_FLUSH];

  assign job_pop  = (state_q == LOAD);
  assign res_push = (state_q == STORE) & ~res_full & ~flush;
  assign unused_bits = ^sdata_in[31:24];

  mul_sched_fifo #(.W(JOB_W), .D(QDEPTH)) u_jobq (
    .clk     (clk),
    .rst_n   (n_reset),
    .push_i  (wr_a2),
    .pop_i   (job_pop),
    .flush_i (flush),
    .data_i  ({a1_q, sdata_in[23:0]}),
    .data_o  (job_head),
    .full_o  (job_full),
    .empty_o (job_empty),
    .count_o (job_cnt)
  );

  mul_sched_fifo #(.W(RES_W), .D(QDEPTH)) u_resq (
    .clk     (clk),
    .rst_n   (n_reset),
    .push_i  (res_push),
    .pop_i   (rd_w),
    .flush_i (flush),
    .data_i  ({w_q, v_q, l_q}),
    .data_o  (res_head),
    .full_o  (res_full),
    .empty_o (res_empty),
    .count_o (res_cnt)
  );

  always_comb begin
    status = '0;
    status[ST_BUSY]    = (state_q != IDLE);
    status[ST_JCNT+:3] = 3'(job_cnt);
    status[ST_RCNT+:3] = 3'(res_cnt);
    status[ST_EFULL]   = err_full_q;
    status[ST_EEMPTY]  = err_empty_q;
    status[ST_IEN]     = ien_q;
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (saddress == ADDR_W):
        rdata = res_empty ? '0 : res_head[38:7];
      (saddress == ADDR_L):
        rdata = res_empty ? '0 : {25'h0, res_head[6:0]};
      (saddress == ADDR_CSR):
        rdata = status;
      default: rdata = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    bit_cnt_d = bit_cnt_q;
    w_d       = w_q;
    v_d       = v_q;
    l_d       = l_q;
    unique case (state_q)
      IDLE: if (!job_empty) state_d = LOAD;
      LOAD: begin
        acc_d     = '0;
        mcand_d   = {24'h0, job_head[47:24]};
        mplier_d  = job_head[23:0];
        bit_cnt_d = '0;
        state_d   = MUL;
      end
      MUL: begin
        if (mplier_q[0])
          acc_d = acc_q + mcand_q;
        mcand_d   = mcand_q << 1;
        mplier_d  = mplier_q >> 1;
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd23)
          state_d = POP;
      end
      POP: begin
        l_d     = popcnt32(acc_q[31:0]);
        v_d     = (acc_q[47:32] == 16'h0);
        w_d     = acc_q[31:0];
        state_d = STORE;
      end
      STORE:
        if (!res_full)
          state_d = job_empty ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
    if (flush)
      state_d = IDLE;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      bit_cnt_q <= '0;
      w_q       <= '0;
      v_q       <= 1'b0;
      l_q       <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      bit_cnt_q <= bit_cnt_d;
      w_q       <= w_d;
      v_q       <= v_d;
      l_q       <= l_d;
    end
  end

  // Error set takes priority over a same-cycle clear.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      a1_q        <= '0;
      op_cnt_q    <= '0;
      sdata_out_q <= '0;
      err_full_q  <= 1'b0;
      err_empty_q <= 1'b0;
      ien_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      if (flush)
        a1_q <= '0;
      else if (wr_a1)
        a1_q <= sdata_in[23:0];
      if (res_push)
        op_cnt_q <= op_cnt_q + 16'd1;
      if (srd)
        sdata_out_q <= rdata;
      if (wr_csr) begin
        ien_q <= sdata_in[CT_IEN];
        if (sdata_in[CT_CLR]) begin
          err_full_q  <= 1'b0;
          err_empty_q <= 1'b0;
        end
      end
      if (wr_a2 && job_full)
        err_full_q <= 1'b1;
      if (rd_w && res_empty)
        err_empty_q <= 1'b1;
      irq_q <= ien_q & (res_cnt != '0);
    end
  end

  assign sdata_out = sdata_out_q;
  assign gpio_out  = {16'h0, op_cnt_q};
  assign irq       = irq_q;

endmodule

// File: tb/tb_gpio_mul_sched.sv
// Directed bench for gpio_mul_sched: latency, ordering,
// overflow, stall, irq and flush behaviour.
module tb_gpio_mul_sched;
  import gpio_mul_pkg::*;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [15:0] saddress = '0;
  logic        srd = 1'b0;
  logic        swr = 1'b0;
  logic [31:0] sdata_in = '0;
  logic [31:0] sdata_out;
  logic [31:0] gpio_out;
  logic        irq;

  int errs = 0;
  int checks = 0;

  gpio_mul_sched #(.QDEPTH(4)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .saddress  (saddress),
    .srd       (srd),
    .swr       (swr),
    .sdata_in  (sdata_in),
    .sdata_out (sdata_out),
    .gpio_out  (gpio_out),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  logic [31:0] last_gpio = '0;
  time         ev_t [32];
  int          ev_n = 0;

  always @(negedge clk) begin
    if (gpio_out != last_gpio) begin
      if (ev_n < 32)
        ev_t[ev_n] <= $time;
      ev_n      <= ev_n + 1;
      last_gpio <= gpio_out;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h want 0x%08h",
               tag, got, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a,
                    input logic [31:0] d);
    @(negedge clk);
    saddress = a;
    sdata_in = d;
    swr = 1'b1;
    @(negedge clk);
    swr = 1'b0;
  endtask

  task automatic rd_chk(input string tag,
                        input logic [15:0] a,
                        input logic [31:0] exp);
    @(negedge clk);
    saddress = a;
    srd = 1'b1;
    @(negedge clk);
    srd = 1'b0;
    check(tag, sdata_out, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ev(input int n, input int bound);
    int i;
    i = 0;
    while (ev_n < n && i < bound) begin
      @(posedge clk);
      i++;
    end
    check("wait_ev", 32'(ev_n >= n), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int base;
    idle(3);
    n_reset = 1'b1;
    check("rst_sdata", sdata_out, 32'h0);
    check("rst_gpio", gpio_out, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    wr(ADDR_A1, 32'd3);
    wr(ADDR_A2, 32'd5);
    idle(5);
    rd_chk("busy_mid", ADDR_CSR, 32'h1);
    n_reset = 1'b0;
    #1;
    check("mid_rst_sdata", sdata_out, 32'h0);
    check("mid_rst_gpio", gpio_out, 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);
    idle(2);
    n_reset = 1'b1;
    rd_chk("rst_status", ADDR_CSR, 32'h0);
    rd_chk("rst_w_empty", ADDR_W, 32'h0);
    rd_chk("err_empty", ADDR_CSR, 32'h100);
    wr(ADDR_CSR, 32'h1);
    rd_chk("err_clr", ADDR_CSR, 32'h0);

    wr(ADDR_A1, 32'd3);
    wr(ADDR_A2, 32'd5);
    idle(27);
    check("lat_e27", gpio_out, 32'd0);
    idle(1);
    check("lat_e28", gpio_out, 32'd1);
    rd_chk("st_one", ADDR_CSR, 32'h10);
    rd_chk("peek_3x5", ADDR_L, 32'h44);
    rd_chk("pop_3x5", ADDR_W, 32'd15);
    check("gpio_1", gpio_out, 32'd1);

    wr(ADDR_CSR, 32'h4);
    wr(ADDR_A1, 32'h00FF_FFFF);
    wr(ADDR_A2, 32'h00FF_FFFF);
    idle(28);
    check("irq_e28", 32'(irq), 32'd0);
    idle(1);
    check("irq_e29", 32'(irq), 32'd1);
    check("gpio_2", gpio_out, 32'd2);
    rd_chk("peek_max", ADDR_L, 32'h08);
    rd_chk("pop_max", ADDR_W, 32'hFE00_0001);
    check("irq_hold", 32'(irq), 32'd1);
    idle(1);
    check("irq_fall", 32'(irq), 32'd0);

    wr(ADDR_CSR, 32'h0);
    wr(ADDR_A1, 32'd7);
    wr(ADDR_A2, 32'd9);
    idle(4);
    base = ev_n;
    @(negedge clk);
    saddress = ADDR_A2;
    swr = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      sdata_in = 32'(k);
      @(negedge clk);
    end
    swr = 1'b0;
    rd_chk("full_flag", ADDR_CSR, 32'h89);
    wait_ev(base + 1, 60);
    rd_chk("pop_job0", ADDR_W, 32'd63);
    wait_ev(base + 5, 150);
    for (int k = 1; k <= 4; k++)
      check("spacing",
            32'(ev_t[base+k] - ev_t[base+k-1]),
            32'd270);
    rd_chk("st_four", ADDR_CSR, 32'hC0);
    for (int k = 1; k <= 4; k++)
      rd_chk("pop_order", ADDR_W, 32'(7 * k));
    check("gpio_7", gpio_out, 32'd7);
    wr(ADDR_CSR, 32'h1);

    wr(ADDR_A1, 32'd2);
    for (int k = 1; k <= 4; k++)
      wr(ADDR_A2, 32'(k));
    idle(60);
    wr(ADDR_A2, 32'd5);
    wr(ADDR_A2, 32'd6);
    idle(200);
    rd_chk("stall_st", ADDR_CSR, 32'h43);
    check("stall_gpio", gpio_out, 32'd11);
    rd_chk("stall_pop", ADDR_W, 32'd2);
    check("stall_hold", gpio_out, 32'd11);
    idle(1);
    check("stall_rel", gpio_out, 32'd12);

    wr(ADDR_CSR, 32'h4);
    idle(1);
    check("irq_on", 32'(irq), 32'd1);
    wr(ADDR_CSR, 32'h2);
    check("flush_irq_lag", 32'(irq), 32'd1);
    idle(1);
    check("flush_irq", 32'(irq), 32'd0);
    rd_chk("flush_st", ADDR_CSR, 32'h0);
    check("flush_ops", gpio_out, 32'd12);
    rd_chk("unmapped", 16'h0384, 32'h0);
    wr(ADDR_A2, 32'd5);
    idle(30);
    rd_chk("a1_cleared", ADDR_L, 32'h40);
    check("post_ops", gpio_out, 32'd13);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
